// File: rtl/program_memory_arbiter.sv
// Arbitrates a shared single-port program memory between an instruction
// fetch port and a debug read/write port. Each requester owns one pending
// slot; ties are broken round-robin, with fetch winning the first tie.
//
// state  | meaning
// IDLE   | no access in flight; pick the next pending requester
// F_ACC  | fetch access: memory addressed with the latched fetch word index
// D_ACC  | debug access: memory addressed (and written) for the latched request
module program_memory_arbiter #(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [DATA_WIDTH-1:0] fetch_addr,
  output logic                  fetch_busy,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_instr,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [DATA_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_busy,
  output logic                  dbg_valid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_err,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, F_ACC, D_ACC} state_t;

  localparam logic [DATA_WIDTH-1:0] DEPTH_W = DATA_WIDTH'(MEMORY_DEPTH);

  state_t                state;
  logic                  last_dbg;
  logic [DATA_WIDTH-1:0] f_addr;
  logic [DATA_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_we;
  logic                  f_accept;
  logic                  d_accept;

  function automatic logic [DATA_WIDTH-1:0] word_idx(input logic [DATA_WIDTH-1:0] a);
    return {2'b00, a[DATA_WIDTH-1:2]};
  endfunction

  // misaligned or beyond the end of the memory
  function automatic logic addr_bad(input logic [DATA_WIDTH-1:0] a);
    return (a[1:0] != 2'b00) || (word_idx(a) >= DEPTH_W);
  endfunction

  // busy doubles as the pending flag, so a strobe is only taken into an empty slot
  assign f_accept = fetch_req && !fetch_busy;
  assign d_accept = dbg_req && !dbg_busy;

  // capture request payloads when a strobe is accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_addr  <= '0;
      d_addr  <= '0;
      d_wdata <= '0;
      d_we    <= 1'b0;
    end else begin
      if (f_accept) f_addr <= fetch_addr;
      if (d_accept) begin
        d_addr  <= dbg_addr;
        d_wdata <= dbg_wdata;
        d_we    <= dbg_we;
      end
    end
  end

  // arbitration FSM with pending flags and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_dbg    <= 1'b1;
      fetch_busy  <= 1'b0;
      dbg_busy    <= 1'b0;
      fetch_valid <= 1'b0;
      dbg_valid   <= 1'b0;
      dbg_err     <= 1'b0;
      fetch_instr <= '0;
      dbg_rdata   <= '0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
    end else begin
      fetch_valid <= 1'b0;
      dbg_valid   <= 1'b0;
      dbg_err     <= 1'b0;
      if (f_accept) fetch_busy <= 1'b1;
      if (d_accept) dbg_busy   <= 1'b1;
      case (state)
        IDLE: begin
          if (fetch_busy && (!dbg_busy || last_dbg)) begin
            state    <= F_ACC;
            mem_addr <= word_idx(f_addr);
          end else if (dbg_busy) begin
            state     <= D_ACC;
            mem_addr  <= word_idx(d_addr);
            mem_we    <= d_we && !addr_bad(d_addr);
            mem_wdata <= d_wdata;
          end
        end
        F_ACC: begin
          fetch_instr <= addr_bad(f_addr) ? '0 : mem_rdata;
          fetch_valid <= 1'b1;
          fetch_busy  <= 1'b0;
          last_dbg    <= 1'b0;
          mem_addr    <= '0;
          state       <= IDLE;
        end
        D_ACC: begin
          dbg_rdata <= (d_we || addr_bad(d_addr)) ? '0 : mem_rdata;
          dbg_err   <= addr_bad(d_addr);
          dbg_valid <= 1'b1;
          dbg_busy  <= 1'b0;
          last_dbg  <= 1'b1;
          mem_addr  <= '0;
          mem_we    <= 1'b0;
          mem_wdata <= '0;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          mem_addr  <= '0;
          mem_we    <= 1'b0;
          mem_wdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_memory_arbiter.sv
// Scoreboard bench for program_memory_arbiter: directed requests push their
// expected completions (data, error, cycle) into queues; a monitor pops and
// compares whenever the DUT pulses a valid or a memory write.
module tb_program_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_busy, fetch_valid;
  logic [31:0] fetch_instr;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] dbg_addr = '0, dbg_wdata = '0;
  logic        dbg_busy, dbg_valid, dbg_err;
  logic [31:0] dbg_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  program_memory_arbiter #(.MEMORY_DEPTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_busy(fetch_busy),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_busy(dbg_busy), .dbg_valid(dbg_valid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory model: untouched words read a fixed pattern, word 2 holds 0x20080005
  bit   [31:0] wvalid;
  logic [31:0] wmem [32];

  function automatic logic [31:0] init_val(input int i);
    return (i == 2) ? 32'h20080005 : (32'hA5A50000 | 32'(i));
  endfunction

  assign mem_rdata = (mem_addr < 32) ?
                     (wvalid[mem_addr[4:0]] ? wmem[mem_addr[4:0]] : init_val(int'(mem_addr[4:0]))) :
                     32'h0;

  always @(posedge clk) begin
    if (mem_we && mem_addr < 32) begin
      wmem[mem_addr[4:0]]   <= mem_wdata;
      wvalid[mem_addr[4:0]] <= 1'b1;
    end
  end

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
    logic [31:0] addr;
  } exp_t;

  exp_t fq[$];
  exp_t dq[$];
  exp_t wq[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit done  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got unexpected event expected none (cycle %0d)", name, cyc);
  endtask

  task automatic monitor();
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (fetch_valid) begin
        if (fq.size() == 0) flag("fetch_extra_valid");
        else begin
          e = fq.pop_front();
          check("fetch_instr", fetch_instr, e.data);
          check("fetch_cycle", 32'(cyc), 32'(e.cyc));
          check("fetch_busy_fall", {31'b0, fetch_busy}, 32'h0);
        end
      end else if (fq.size() > 0 && cyc > fq[0].cyc) begin
        e = fq.pop_front();
        flag("fetch_valid_timeout");
      end
      if (dbg_valid) begin
        if (dq.size() == 0) flag("dbg_extra_valid");
        else begin
          e = dq.pop_front();
          check("dbg_rdata", dbg_rdata, e.data);
          check("dbg_err", {31'b0, dbg_err}, {31'b0, e.err});
          check("dbg_cycle", 32'(cyc), 32'(e.cyc));
          check("dbg_busy_fall", {31'b0, dbg_busy}, 32'h0);
        end
      end else if (dq.size() > 0 && cyc > dq[0].cyc) begin
        e = dq.pop_front();
        flag("dbg_valid_timeout");
      end
      if (mem_we) begin
        if (wq.size() == 0) flag("mem_we_unexpected");
        else begin
          e = wq.pop_front();
          check("mem_we_addr", mem_addr, e.addr);
          check("mem_wdata", mem_wdata, e.data);
          check("mem_we_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      fetch_req = 1'b0;
      dbg_req   = 1'b0;
    end
  endtask

  // drive a one-cycle fetch strobe and expect its completion three cycles later
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp_data, input int lat);
    fetch_req  = 1'b1;
    fetch_addr = a;
    fq.push_back('{cyc: cyc + lat, data: exp_data, err: 1'b0, addr: 32'h0});
  endtask

  task automatic do_dbg(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_data, input logic exp_err, input int lat);
    dbg_req   = 1'b1;
    dbg_we    = we;
    dbg_addr  = a;
    dbg_wdata = wd;
    dq.push_back('{cyc: cyc + lat, data: exp_data, err: exp_err, addr: 32'h0});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fetch_busy"},  {31'b0, fetch_busy},  32'h0);
    check({tag, "_dbg_busy"},    {31'b0, dbg_busy},    32'h0);
    check({tag, "_fetch_valid"}, {31'b0, fetch_valid}, 32'h0);
    check({tag, "_dbg_valid"},   {31'b0, dbg_valid},   32'h0);
    check({tag, "_dbg_err"},     {31'b0, dbg_err},     32'h0);
    check({tag, "_mem_we"},      {31'b0, mem_we},      32'h0);
    check({tag, "_mem_addr"},    mem_addr,    32'h0);
    check({tag, "_mem_wdata"},   mem_wdata,   32'h0);
    check({tag, "_fetch_instr"}, fetch_instr, 32'h0);
    check({tag, "_dbg_rdata"},   dbg_rdata,   32'h0);
  endtask

  task automatic run_stim();
    tick(3);
    check_all_zero("reset");

    // release and strobe both ports on the first edge: fetch wins the first tie
    reset = 1'b1;
    do_fetch(32'h8, 32'h20080005, 3);
    do_dbg(1'b0, 32'h4, 32'h0, 32'hA5A50001, 1'b0, 5);
    tick(1);
    check("tie_fetch_busy", {31'b0, fetch_busy}, 32'h1);
    check("tie_dbg_busy",   {31'b0, dbg_busy},   32'h1);
    tick(1);
    check("tie_fetch_mem_addr", mem_addr, 32'h2);
    tick(2);
    check("tie_dbg_mem_addr", mem_addr, 32'h1);
    tick(3);

    // lone fetch of word 0
    do_fetch(32'h0, 32'hA5A50000, 3);
    tick(4);

    // debug write then read back
    do_dbg(1'b1, 32'hC, 32'hDEADBEEF, 32'h0, 1'b0, 3);
    wq.push_back('{cyc: cyc + 2, data: 32'hDEADBEEF, err: 1'b0, addr: 32'h3});
    tick(4);
    do_dbg(1'b0, 32'hC, 32'h0, 32'hDEADBEEF, 1'b0, 3);
    tick(4);

    // fetch served last, so debug wins the next tie
    do_fetch(32'h0, 32'hA5A50000, 3);
    tick(4);
    do_fetch(32'h8, 32'h20080005, 5);
    do_dbg(1'b0, 32'h8, 32'h0, 32'h20080005, 1'b0, 3);
    tick(6);

    // address faults
    do_dbg(1'b1, 32'h80, 32'h12345678, 32'h0, 1'b1, 3);
    tick(4);
    do_dbg(1'b0, 32'h2, 32'h0, 32'h0, 1'b1, 3);
    tick(4);
    do_fetch(32'h6, 32'h0, 3);
    tick(4);

    // second strobe while busy is ignored; strobe in the valid cycle is taken
    do_fetch(32'h10, 32'hA5A50004, 3);
    tick(1);
    check("bp_fetch_busy", {31'b0, fetch_busy}, 32'h1);
    fetch_req  = 1'b1;
    fetch_addr = 32'h14;
    tick(1);
    check("bp_mem_addr", mem_addr, 32'h4);
    tick(1);
    do_fetch(32'h18, 32'hA5A50006, 3);
    tick(1);
    check("bp_next_mem_addr", mem_addr, 32'h0);
    tick(4);

    // reset in the middle of a debug access aborts it without a valid pulse
    dbg_req   = 1'b1;
    dbg_we    = 1'b0;
    dbg_addr  = 32'h10;
    tick(2);
    check("abort_mem_addr", mem_addr, 32'h4);
    reset = 1'b0;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    reset = 1'b1;
    do_fetch(32'h8, 32'h20080005, 3);
    tick(6);

    check("fq_drained", 32'(fq.size()), 32'h0);
    check("dq_drained", 32'(dq.size()), 32'h0);
    check("wq_drained", 32'(wq.size()), 32'h0);
    done = 1'b1;
  endtask

  initial begin
    fork
      monitor();
      run_stim();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
